// File: rtl/gpio_bidir_pkg.sv
// Shared register offsets and helpers for the Wishbone bidirectional GPIO controller.
package gpio_bidir_pkg;

    localparam logic [2:0] GPIO_DATA_IN    = 3'd0;
    localparam logic [2:0] GPIO_DATA_OUT   = 3'd1;
    localparam logic [2:0] GPIO_DIR        = 3'd2;
    localparam logic [2:0] GPIO_RISE_EN    = 3'd3;
    localparam logic [2:0] GPIO_FALL_EN    = 3'd4;
    localparam logic [2:0] GPIO_IRQ_STATUS = 3'd5;
    localparam logic [2:0] GPIO_OUT_SET    = 3'd6;
    localparam logic [2:0] GPIO_OUT_CLR    = 3'd7;

    localparam int GPIO_MAX_PINS = 32;

    // Expand the four Wishbone byte selects into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_bidir_wb_sync_edge.sv
// Input synchroniser, edge history and arm counter producing qualified rise/fall pulses.
module gpio_sync_edge
    import gpio_bidir_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] dir,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [ARM_W-1:0]                  arm_q, arm_d;
    logic                              armed;

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign armed  = (arm_q == ARM_W'(ARM_MAX));

    always_comb begin
        sync_d[0] = pad_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_o;
        arm_d  = armed ? arm_q : arm_q + 1'b1;
    end

    // Edges are suppressed until the chain has flushed its reset zeros.
    always_comb begin
        rise_o = '0;
        fall_o = '0;
        if (armed) begin
            rise_o = sync_o & ~prev_q & rise_en & ~dir;
            fall_o = ~sync_o & prev_q & fall_en & ~dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

endmodule

// File: rtl/gpio_bidir_wb.sv
// Wishbone slave GPIO controller: direction, output data, set/clear, edge IRQ status.
module gpio_bidir_wb
    import gpio_bidir_pkg::*;
#(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          wb_adr,
    input  logic [31:0]         wb_dat_w,
    output logic [31:0]         wb_dat_r,
    input  logic [3:0]          wb_sel,
    input  logic                wb_we,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    output logic                wb_ack,
    output logic                wb_stall,
    output logic                wb_err,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic [NUM_PINS-1:0] gpio_snoop,
    output logic                irq_o
);

    if (NUM_PINS < 1 || NUM_PINS > GPIO_MAX_PINS) begin : g_bad_pins
        $error("gpio_bidir_wb: NUM_PINS out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("gpio_bidir_wb: SYNC_STAGES out of range");
    end

    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0] irq_status_q, irq_status_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_r_q, dat_r_d;

    logic                req, wr;
    logic [31:0]         mask32, wdat32;
    logic [NUM_PINS-1:0] wmask, wdat, w1c;
    logic [NUM_PINS-1:0] sync, rise, fall, rd_pins;
    logic [31:0]         rdata;

    gpio_sync_edge #(
        .WIDTH      (NUM_PINS),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pad_i  (gpio_i),
        .rise_en(rise_en_q),
        .fall_en(fall_en_q),
        .dir    (dir_q),
        .sync_o (sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Every cyc&stb cycle is one access; no stall, so ack simply follows by a cycle.
    assign req    = wb_cyc & wb_stb;
    assign wr     = req & wb_we;
    assign mask32 = byte_mask(wb_sel);
    assign wdat32 = wb_dat_w & mask32;
    assign wmask  = mask32[NUM_PINS-1:0];
    assign wdat   = wdat32[NUM_PINS-1:0];

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        w1c        = '0;
        if (wr) begin
            case (wb_adr)
                GPIO_DATA_OUT:   data_out_d = (data_out_q & ~wmask) | wdat;
                GPIO_DIR:        dir_d      = (dir_q & ~wmask) | wdat;
                GPIO_RISE_EN:    rise_en_d  = (rise_en_q & ~wmask) | wdat;
                GPIO_FALL_EN:    fall_en_d  = (fall_en_q & ~wmask) | wdat;
                GPIO_IRQ_STATUS: w1c        = wdat;
                GPIO_OUT_SET:    data_out_d = data_out_q | wdat;
                GPIO_OUT_CLR:    data_out_d = data_out_q & ~wdat;
                default:         ;
            endcase
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        irq_status_d = (irq_status_q & ~w1c) | rise | fall;
    end

    always_comb begin
        rd_pins = '0;
        case (wb_adr)
            GPIO_DATA_IN:    rd_pins = sync;
            GPIO_DATA_OUT:   rd_pins = data_out_q;
            GPIO_DIR:        rd_pins = dir_q;
            GPIO_RISE_EN:    rd_pins = rise_en_q;
            GPIO_FALL_EN:    rd_pins = fall_en_q;
            GPIO_IRQ_STATUS: rd_pins = irq_status_q;
            default:         rd_pins = '0;
        endcase
        rdata               = '0;
        rdata[NUM_PINS-1:0] = rd_pins;
        dat_r_d             = (req && !wb_we) ? rdata : '0;
        ack_d               = req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            ack_q        <= 1'b0;
            dat_r_q      <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            ack_q        <= ack_d;
            dat_r_q      <= dat_r_d;
        end
    end

    assign wb_ack     = ack_q;
    assign wb_dat_r   = dat_r_q;
    assign wb_stall   = 1'b0;
    assign wb_err     = 1'b0;
    assign gpio_o     = data_out_q;
    assign gpio_oe    = dir_q;
    assign gpio_snoop = (dir_q & data_out_q) | (~dir_q & gpio_i);
    assign irq_o      = |irq_status_q;

endmodule

// File: tb/tb_gpio_bidir_wb.sv
// Directed bench for gpio_bidir_wb: read data checked by an ack-driven scoreboard, pins/IRQ checked inline.
module tb_gpio_bidir_wb;
    import gpio_bidir_pkg::*;

    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    wb_adr;
    logic [31:0]   wb_dat_w;
    logic [31:0]   wb_dat_r;
    logic [3:0]    wb_sel;
    logic          wb_we, wb_cyc, wb_stb;
    logic          wb_ack, wb_stall, wb_err;
    logic [NP-1:0] gpio_i, gpio_o, gpio_oe, gpio_snoop;
    logic          irq_o;

    logic [31:0] exp_q[$];
    logic        chk_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    gpio_bidir_wb #(.NUM_PINS(NP), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_dat_r  (wb_dat_r),
        .wb_sel    (wb_sel),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall),
        .wb_err    (wb_err),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe   (gpio_oe),
        .gpio_snoop(gpio_snoop),
        .irq_o     (irq_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every ack consumes one scoreboard entry; reads compare data
    always @(negedge clk) begin
        if (wb_ack === 1'b1) begin
            n_checks++;
            if (chk_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_ack: got ack with %0d pending, expected none", chk_q.size());
            end else if (chk_q.pop_front()) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (wb_dat_r !== e) begin
                    n_errors++;
                    $display("FAIL read_data: got %h expected %h", wb_dat_r, e);
                end
            end
        end
    end

    // driver tasks
    task automatic bus_req(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input logic [31:0] exp);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_adr   = adr;
        wb_dat_w = dat;
        wb_sel   = sel;
        wb_we    = we;
        chk_q.push_back(!we);
        if (!we) exp_q.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_idle();
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus_req(adr, dat, sel, 1'b1, 32'h0);
        bus_idle();
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] exp);
        bus_req(adr, 32'h0, 4'hF, 1'b0, exp);
        bus_idle();
    endtask

    initial begin
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; gpio_i = 16'h00FF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_ack", 32'(wb_ack), 32'h0);
        check("rst_dat_r", wb_dat_r, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        rst = 1'b0;

        // pads high through reset must not look like rising edges
        wr(GPIO_RISE_EN, 32'h0000_00FF, 4'hF);
        idle(6);
        rd(GPIO_IRQ_STATUS, 32'h0);
        rd(GPIO_DATA_IN, 32'h0000_00FF);
        check("arm_irq", 32'(irq_o), 32'h0);
        wr(GPIO_RISE_EN, 32'h0, 4'hF);

        // direction / output data / snoop
        wr(GPIO_DIR, 32'h0000_000F, 4'hF);
        wr(GPIO_DATA_OUT, 32'h0000_00A5, 4'hF);
        gpio_i = 16'h5A30;
        bus_idle();
        check("gpio_oe", 32'(gpio_oe), 32'h0000_000F);
        check("gpio_o", 32'(gpio_o), 32'h0000_00A5);
        check("snoop", 32'(gpio_snoop), 32'h0000_5A35);

        // back-to-back SET / CLR
        bus_req(GPIO_OUT_SET, 32'h0000_0002, 4'hF, 1'b1, 32'h0);
        check("ack_b2b_1", 32'(wb_ack), 32'h1);
        bus_req(GPIO_OUT_CLR, 32'h0000_0080, 4'hF, 1'b1, 32'h0);
        check("ack_b2b_2", 32'(wb_ack), 32'h1);
        bus_idle();
        check("gpio_o_setclr", 32'(gpio_o), 32'h0000_0027);
        rd(GPIO_OUT_SET, 32'h0);
        rd(GPIO_DATA_OUT, 32'h0000_0027);

        // rising edge on pin 4: irq exactly 3 clocks after the pad change
        gpio_i = 16'h5A20;
        idle(4);
        wr(GPIO_RISE_EN, 32'h0000_0010, 4'hF);
        gpio_i = 16'h5A30;
        @(posedge clk); #1;
        check("irq_lat_1", 32'(irq_o), 32'h0);
        @(posedge clk); #1;
        check("irq_lat_2", 32'(irq_o), 32'h0);
        @(posedge clk); #1;
        check("irq_lat_3", 32'(irq_o), 32'h1);
        rd(GPIO_IRQ_STATUS, 32'h0000_0010);
        wr(GPIO_IRQ_STATUS, 32'h0000_0010, 4'hF);
        check("irq_cleared", 32'(irq_o), 32'h0);

        // W1C coincident with a new rising edge: set wins
        gpio_i = 16'h5A20;
        idle(4);
        gpio_i = 16'h5A30;
        idle(5);
        gpio_i = 16'h5A20;
        idle(4);
        gpio_i = 16'h5A30;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_req(GPIO_IRQ_STATUS, 32'h0000_0010, 4'hF, 1'b1, 32'h0);
        bus_idle();
        rd(GPIO_IRQ_STATUS, 32'h0000_0010);
        wr(GPIO_IRQ_STATUS, 32'h0000_0010, 4'hF);
        rd(GPIO_IRQ_STATUS, 32'h0);

        // FALL_EN-only pin: rising edge ignored, falling edge sets status
        wr(GPIO_RISE_EN, 32'h0, 4'hF);
        gpio_i = 16'h5A10;
        idle(4);
        wr(GPIO_FALL_EN, 32'h0000_0020, 4'hF);
        gpio_i = 16'h5A30;
        idle(5);
        rd(GPIO_IRQ_STATUS, 32'h0);
        gpio_i = 16'h5A10;
        idle(5);
        rd(GPIO_IRQ_STATUS, 32'h0000_0020);
        check("irq_fall", 32'(irq_o), 32'h1);
        wr(GPIO_FALL_EN, 32'h0, 4'hF);
        rd(GPIO_IRQ_STATUS, 32'h0000_0020);
        wr(GPIO_IRQ_STATUS, 32'h0000_0020, 4'b0010);
        rd(GPIO_IRQ_STATUS, 32'h0000_0020);
        wr(GPIO_IRQ_STATUS, 32'h0000_0020, 4'b0001);
        rd(GPIO_IRQ_STATUS, 32'h0);

        // output-configured pin toggled externally never sets status
        wr(GPIO_RISE_EN, 32'h0000_0001, 4'hF);
        wr(GPIO_FALL_EN, 32'h0000_0001, 4'hF);
        gpio_i = 16'h5A11;
        idle(5);
        check("snoop_out_pin", 32'(gpio_snoop), 32'h0000_5A17);
        gpio_i = 16'h5A10;
        idle(5);
        rd(GPIO_IRQ_STATUS, 32'h0);

        // byte-lane gating and unimplemented upper bits
        wr(GPIO_DATA_OUT, 32'h0000_FF00, 4'b0010);
        rd(GPIO_DATA_OUT, 32'h0000_FF27);
        wr(GPIO_DATA_OUT, 32'h1234_5678, 4'b0001);
        check("gpio_o_sel", 32'(gpio_o), 32'h0000_FF78);
        wr(GPIO_DIR, 32'hFFFF_FFFF, 4'hF);
        rd(GPIO_DIR, 32'h0000_FFFF);

        // strobe without cyc is ignored
        wb_cyc = 1'b0; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = GPIO_DIR; wb_dat_w = 32'h0; wb_sel = 4'hF;
        @(posedge clk); #1;
        check("no_cyc_ack", 32'(wb_ack), 32'h0);
        bus_idle();
        rd(GPIO_DIR, 32'h0000_FFFF);

        // reset in the would-be ack cycle kills the ack
        rst = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = GPIO_DATA_OUT;
        @(posedge clk); #1;
        check("rst_kills_ack", 32'(wb_ack), 32'h0);
        bus_idle();
        rst = 1'b0;
        check("rst2_gpio_o", 32'(gpio_o), 32'h0);
        check("rst2_gpio_oe", 32'(gpio_oe), 32'h0);

        for (int i = 0; i < 50 && chk_q.size() != 0; i++) @(posedge clk);
        check("drain", 32'(chk_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_bidir_wb.md
Name: gpio_bidir_wb

Overview:
Parametrised Wishbone GPIO controller with NUM_PINS bidirectional pins, generalising the fixed-width gpio0/gpio1 ports and the per-port bidirectional (de)muxing with snoop outputs done at top level. Per-pin direction, output data, atomic set/clear, input synchronisation, rise/fall edge detection and a sticky, write-1-to-clear interrupt status drive one level IRQ. Sits on the SoC Wishbone bus as a slave. Pad tristating (`oe ? o : 'Z`) remains in the top level.

Parameters:
NUM_PINS, 8, number of GPIO pins, legal range 1..32.
SYNC_STAGES, 2, input synchroniser depth, legal range 2..4.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
wb_adr  in  3  word address.
wb_dat_w  in  32  write data.
wb_dat_r  out  32  read data.
wb_sel  in  4  byte selects.
wb_we  in  1  write enable.
wb_cyc  in  1  bus cycle.
wb_stb  in  1  strobe.
wb_ack  out  1  acknowledge.
wb_stall  out  1  tied 0.
wb_err  out  1  tied 0.
gpio_i  in  NUM_PINS  raw pad inputs, asynchronous.
gpio_o  out  NUM_PINS  output data.
gpio_oe  out  NUM_PINS  per-pin output enable, 1 = drive.
gpio_snoop  out  NUM_PINS  pad value: gpio_oe ? gpio_o : gpio_i, combinational, per bit.
irq_o  out  1  interrupt, level high.

Behaviour:
- Register map (word offset), bits above NUM_PINS read 0 and ignore writes: 0 DATA_IN RO (synchronised input); 1 DATA_OUT RW; 2 DIR RW (1 = output); 3 RISE_EN RW; 4 FALL_EN RW; 5 IRQ_STATUS R/W1C; 6 OUT_SET WO (DATA_OUT |= wdata), reads 0; 7 OUT_CLR WO (DATA_OUT &= ~wdata), reads 0.
- Reset: all registers 0, gpio_o = 0, gpio_oe = 0, wb_ack = 0, wb_dat_r = 0, irq_o = 0. Synchroniser flops and edge-history register = 0. Arm counter = 0.
- Wishbone: one access per cyc&stb cycle. wb_ack rises exactly 1 cycle after cyc&stb and stays high for 1 cycle; wb_dat_r is valid with ack. Back-to-back strobes are acked on consecutive cycles. Writes take effect on the ack cycle edge. Byte lanes are gated by wb_sel for all writable registers, including SET/CLR/W1C. A strobe with cyc = 0 is ignored. A reset in the ack cycle kills the ack.
- gpio_o = DATA_OUT, gpio_oe = DIR, both straight from flops. A pin change is visible on the pad 1 cycle after the write's ack edge.
- Input path: gpio_i -> SYNC_STAGES flop chain -> sync. DATA_IN = sync. A pad change appears in DATA_IN after SYNC_STAGES clocks.
- Edges: prev <= sync every cycle. rise = sync & ~prev & RISE_EN & ~DIR; fall = ~sync & prev & FALL_EN & ~DIR. Output-configured pins never set status.
- Arm: a counter runs from 0 to SYNC_STAGES+1 after reset, then saturates. Edge detection is masked until it saturates, which suppresses spurious edges from pads that are high at reset.
- IRQ_STATUS[i] <= (status[i] & ~w1c[i]) | rise[i] | fall[i]. If an edge and a W1C land in the same cycle, set wins.
- irq_o = |IRQ_STATUS. It is flop-derived, so the delay from pad edge to irq_o is SYNC_STAGES+1 clocks.
- Disabling RISE_EN/FALL_EN does not clear pending status.

Decomposition:
- Package gpio_bidir_pkg holds:
  - word-offset localparams: GPIO_DATA_IN=0, GPIO_DATA_OUT=1, GPIO_DIR=2, GPIO_RISE_EN=3, GPIO_FALL_EN=4, GPIO_IRQ_STATUS=5, GPIO_OUT_SET=6, GPIO_OUT_CLR=7;
  - GPIO_MAX_PINS=32.
- Sub-module gpio_sync_edge(WIDTH, SYNC_STAGES) contains the synchroniser, prev register, arm counter, and rise/fall outputs.
- Register file and Wishbone logic stay in gpio_bidir_wb.

Test Plan:
- Reset with gpio_i = 8'hFF, RISE_EN = FF written right after reset -> no IRQ_STATUS bits set; DATA_IN reads 8'hFF.
- Write DIR = 8'h0F, DATA_OUT = 8'hA5 -> gpio_oe = 0F, gpio_o = A5 one cycle after ack. gpio_snoop low nibble = 5; high nibble follows gpio_i.
- OUT_SET 8'h02 then OUT_CLR 8'h80 on consecutive strobes from DATA_OUT = A5 -> DATA_OUT = 27. Acks arrive on consecutive cycles; OUT_SET reads 0.
- RISE_EN = 8'h10, toggle gpio_i[4] 0->1 -> IRQ_STATUS = 10 and irq_o high exactly 3 clocks later (SYNC_STAGES = 2). Write IRQ_STATUS = 10 -> irq_o low.
- W1C of bit 4 coincident with a new rising edge on pin 4 -> bit stays 1. A FALL_EN-only pin rising produces no status. An output pin toggled externally produces no status.
- wb_sel = 4'b0010 write of 32'h0000_FF00 to DATA_OUT (NUM_PINS = 16) -> only bits 15:8 change. Reading offset 2 with NUM_PINS = 8 -> bits 31:8 are 0.
